// File: rtl/systolic_pkg.sv
// Shared constants, state encoding and display helpers for the systolic
// result display.
package systolic_pkg;

    localparam int ACC_W_DEFAULT   = 16;
    localparam int N_MACS          = 4;
    localparam int N_FRAMES        = 21;   // 4 lanes x 5 frames + 1 gap frame
    localparam int FRAMES_PER_LANE = 5;    // header + 4 nibbles
    localparam int FRAME_W         = 5;    // holds 0..20

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } disp_state_e;

    // Selects nibble (4-k) of a 16-bit word, so k=1 yields the MSB nibble.
    function automatic logic [3:0] nibble_of(input logic [15:0] word,
                                             input logic [2:0]  k);
        logic [3:0] nib;
        case (k)
            3'd1:    nib = word[15:12];
            3'd2:    nib = word[11:8];
            3'd3:    nib = word[7:4];
            3'd4:    nib = word[3:0];
            default: nib = 4'b0000;
        endcase
        return nib;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Frame prescaler: pulses tick on the last cycle of every TICK_DIV-cycle
// window while enabled; the count is held at zero whenever disabled so
// that the first window after enable is full length.
module tick_divider #(
    parameter int TICK_DIV = 62500000    // must be >= 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int                CNT_W  = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]  LAST_C = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_r;

    // Count 0..TICK_DIV-1 while enabled, park at zero otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (!en) begin
            cnt_r <= '0;
        end else if (cnt_r == LAST_C) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign tick = en && (cnt_r == LAST_C);

endmodule

// File: rtl/result_led_display.sv
// Captures the four accumulator results of the systolic array and, once all
// four are present, cycles them out on four LEDs one nibble per frame:
// lane header (one-hot), four nibbles MSB first, repeated per lane, then a
// blank gap frame.
module result_led_display
    import systolic_pkg::*;
#(
    parameter int ACC_W    = ACC_W_DEFAULT,
    parameter int TICK_DIV = 62500000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [ACC_W-1:0] acc_in_0,
    input  logic signed [ACC_W-1:0] acc_in_1,
    input  logic signed [ACC_W-1:0] acc_in_2,
    input  logic signed [ACC_W-1:0] acc_in_3,
    input  logic [3:0]              valid_in,
    input  logic                    busy,
    input  logic                    clear,
    output logic [3:0]              led,
    output logic [3:0]              captured,
    output logic                    showing
);

    localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(N_FRAMES - 1);
    localparam logic [FRAME_W-1:0] FPL        = FRAME_W'(FRAMES_PER_LANE);

    logic [ACC_W-1:0]   acc_s      [N_MACS];
    logic [ACC_W-1:0]   capt_r     [N_MACS];
    logic [15:0]        top16_s    [N_MACS];
    logic [3:0]         captured_r;
    disp_state_e        state_r;
    logic [FRAME_W-1:0] frame_r;
    logic               showing_r;
    logic               tick_s;
    logic               show_en_s;
    logic [1:0]         lane_s;
    logic [2:0]         sub_s;
    logic [3:0]         led_s;

    assign acc_s[0] = acc_in_0;
    assign acc_s[1] = acc_in_1;
    assign acc_s[2] = acc_in_2;
    assign acc_s[3] = acc_in_3;

    // The displayed nibbles always come from the top 16 bits of a lane;
    // narrower accumulators are left-aligned with zero fill.
    for (genvar g = 0; g < N_MACS; g++) begin : g_top16
        if (ACC_W >= 16) begin : g_wide
            assign top16_s[g] = capt_r[g][ACC_W-1 -: 16];
        end else begin : g_narrow
            assign top16_s[g] = {capt_r[g], {(16-ACC_W){1'b0}}};
        end
    end

    // Capture registers: per-lane load on valid, clear wins over valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_MACS; i++) begin
                capt_r[i] <= '0;
            end
            captured_r <= 4'b0000;
        end else if (clear) begin
            for (int i = 0; i < N_MACS; i++) begin
                capt_r[i] <= '0;
            end
            captured_r <= 4'b0000;
        end else begin
            for (int i = 0; i < N_MACS; i++) begin
                if (valid_in[i]) begin
                    capt_r[i]     <= acc_s[i];
                    captured_r[i] <= 1'b1;
                end
            end
        end
    end

    assign show_en_s = (state_r == ST_SHOW);

    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_divider (
        .clk  (clk),
        .rst  (rst),
        .en   (show_en_s),
        .tick (tick_s)
    );

    // Display FSM: waits for all lanes, then steps the frame index on
    // every prescaler tick until cleared or reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            frame_r   <= '0;
            showing_r <= 1'b0;
        end else if (clear) begin
            state_r   <= ST_IDLE;
            frame_r   <= '0;
            showing_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (captured_r == 4'b1111) begin
                        state_r   <= ST_SHOW;
                        frame_r   <= '0;
                        showing_r <= 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (tick_s) begin
                        if (frame_r == LAST_FRAME) begin
                            frame_r <= '0;
                        end else begin
                            frame_r <= frame_r + FRAME_W'(1);
                        end
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    frame_r   <= '0;
                    showing_r <= 1'b0;
                end
            endcase
        end
    end

    assign lane_s = 2'(frame_r / FPL);
    assign sub_s  = 3'(frame_r % FPL);

    // LED decode from registered state only (plus busy while idle).
    always_comb begin
        led_s = {busy, captured_r[2:0]};
        if (state_r == ST_SHOW) begin
            if (frame_r == LAST_FRAME) begin
                led_s = 4'b0000;
            end else if (sub_s == 3'd0) begin
                led_s = 4'b0001 << lane_s;
            end else begin
                led_s = nibble_of(top16_s[lane_s], sub_s);
            end
        end else begin
            led_s = {busy, captured_r[2:0]};
        end
    end

    assign led      = led_s;
    assign captured = captured_r;
    assign showing  = showing_r;

endmodule

// File: tb/tb_result_led_display.sv
// Directed bench for result_led_display with TICK_DIV=4.
module tb_result_led_display;

    logic        clk;
    logic        rst;
    logic [15:0] acc_in_0, acc_in_1, acc_in_2, acc_in_3;
    logic [3:0]  valid_in;
    logic        busy;
    logic        clear;
    logic [3:0]  led;
    logic [3:0]  captured;
    logic        showing;

    int errors = 0;
    int checks = 0;

    result_led_display #(
        .ACC_W    (16),
        .TICK_DIV (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .acc_in_0 (acc_in_0),
        .acc_in_1 (acc_in_1),
        .acc_in_2 (acc_in_2),
        .acc_in_3 (acc_in_3),
        .valid_in (valid_in),
        .busy     (busy),
        .clear    (clear),
        .led      (led),
        .captured (captured),
        .showing  (showing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [15:0] a0, a1, a2, a3;
        logic        clr;
        logic        bsy;
        logic [3:0]  e_led;
        logic [3:0]  e_cap;
        logic        e_show;
    } vec_t;

    vec_t       vecs [5];
    logic [3:0] exp_a [21];
    logic [3:0] exp_b [21];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        // IDLE-phase vectors: capture, busy passthrough, clear priority.
        vecs[0] = '{4'b0101, 16'h1234, 16'h0000, 16'h00FF, 16'h0000, 1'b0, 1'b0, 4'b0101, 4'b0101, 1'b0};
        vecs[1] = '{4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 4'b1101, 4'b0101, 1'b0};
        vecs[2] = '{4'b1111, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b1, 1'b1, 4'b1000, 4'b0000, 1'b0};
        vecs[3] = '{4'b0010, 16'h0000, 16'h7777, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'b0010, 4'b0010, 1'b0};
        vecs[4] = '{4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0};

        exp_a = '{4'h1, 4'h1, 4'h2, 4'h3, 4'h4,
                  4'h2, 4'hA, 4'hB, 4'hC, 4'hD,
                  4'h4, 4'h8, 4'h0, 4'h0, 4'h0,
                  4'h8, 4'hF, 4'hF, 4'hF, 4'hF,
                  4'h0};
        exp_b = exp_a;
        exp_b[7] = 4'h5;
        exp_b[8] = 4'h5;
        exp_b[9] = 4'h5;

        rst = 1'b1; busy = 1'b1; clear = 1'b0; valid_in = 4'b0000;
        acc_in_0 = 16'h0; acc_in_1 = 16'h0; acc_in_2 = 16'h0; acc_in_3 = 16'h0;
        repeat (2) tick();
        chk("reset_led", led, 4'b1000);
        chk("reset_captured", captured, 4'b0000);
        chk("reset_showing", showing, 1'b0);
        rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            valid_in = vecs[v].valid;
            acc_in_0 = vecs[v].a0; acc_in_1 = vecs[v].a1;
            acc_in_2 = vecs[v].a2; acc_in_3 = vecs[v].a3;
            clear = vecs[v].clr; busy = vecs[v].bsy;
            tick();
            busy = vecs[v].bsy;
            chk($sformatf("vec%0d_led", v), led, vecs[v].e_led);
            chk($sformatf("vec%0d_captured", v), captured, vecs[v].e_cap);
            chk($sformatf("vec%0d_showing", v), showing, vecs[v].e_show);
        end
        valid_in = 4'b0000; clear = 1'b0;

        // Full display sequence with busy high (ignored in SHOW).
        busy = 1'b1;
        acc_in_0 = 16'h1234; acc_in_1 = 16'hABCD; acc_in_2 = 16'h8000; acc_in_3 = 16'hFFFF;
        valid_in = 4'b1111;
        tick();
        valid_in = 4'b0000;
        chk("allcap_captured", captured, 4'b1111);
        chk("allcap_showing", showing, 1'b0);
        chk("allcap_led", led, 4'b1111);
        tick();
        for (int f = 0; f < 22; f++) begin
            for (int c = 0; c < 4; c++) begin
                chk($sformatf("seq_f%0d_c%0d", f, c), led, exp_a[f % 21]);
                chk($sformatf("seq_show_f%0d_c%0d", f, c), showing, 1'b1);
                tick();
            end
        end

        // Clear leaves SHOW.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_show_showing", showing, 1'b0);
        chk("clr_show_captured", captured, 4'b0000);
        chk("clr_show_led", led, 4'b1000);

        // Overwrite lane 1 during frame 6.
        valid_in = 4'b1111;
        tick();
        valid_in = 4'b0000;
        tick();
        chk("reentry_f0", led, 4'h1);
        repeat (24) tick();
        chk("ovw_f6_before", led, 4'hA);
        acc_in_1 = 16'h5555;
        valid_in = 4'b0010;
        tick();
        valid_in = 4'b0000;
        repeat (3) tick();
        for (int f = 7; f < 11; f++) begin
            for (int c = 0; c < 4; c++) begin
                chk($sformatf("ovw_f%0d_c%0d", f, c), led, exp_b[f]);
                tick();
            end
        end
        chk("ovw_captured", captured, 4'b1111);

        // Reset during frame 12, then recapture over three cycles.
        repeat (4) tick();
        chk("pre_rst_f12", led, 4'h0);
        chk("pre_rst_showing", showing, 1'b1);
        #2;
        rst = 1'b1;
        busy = 1'b1;
        #1;
        chk("async_rst_led", led, 4'b1000);
        chk("async_rst_captured", captured, 4'b0000);
        chk("async_rst_showing", showing, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_showing", showing, 1'b0);
        acc_in_0 = 16'hC0DE; acc_in_1 = 16'h0001;
        valid_in = 4'b0011;
        tick();
        chk("recap1_captured", captured, 4'b0011);
        chk("recap1_led", led, 4'b1011);
        acc_in_2 = 16'h2222;
        valid_in = 4'b0100;
        tick();
        acc_in_3 = 16'h3333;
        valid_in = 4'b1000;
        tick();
        valid_in = 4'b0000;
        chk("recap3_captured", captured, 4'b1111);
        chk("recap3_showing", showing, 1'b0);
        tick();
        chk("rerun_showing", showing, 1'b1);
        chk("rerun_f0", led, 4'b0001);
        repeat (4) tick();
        chk("rerun_f1", led, 4'hC);
        repeat (4) tick();
        chk("rerun_f2", led, 4'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/result_led_display.md
RESULT_LED_DISPLAY -- requirements
Module: result_led_display

Interface
REQ-001 Parameter ACC_W, default 16, width of each captured accumulator.
REQ-002 Parameter TICK_DIV, default 62500000, clock cycles per display frame (0.5 s at 125 MHz); SHALL be >= 2.
REQ-003 clk  in  1  sole clock; all state SHALL be on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 acc_in_0..acc_in_3  in  ACC_W each, signed  accumulator results from the systolic system.
REQ-006 valid_in  in  4  per-lane result-valid qualifier; bit i qualifies acc_in_i.
REQ-007 busy  in  1  systolic system busy flag.
REQ-008 clear  in  1  single-cycle pulse; discards all captured results.
REQ-009 led  out  4  board LED drive.
REQ-010 captured  out  4  bit i = lane i holds a captured result.
REQ-011 showing  out  1  high while in SHOW state.

Function
REQ-012 Capture: when valid_in[i]=1, acc_in_i SHALL be registered into capture register i and captured[i] SHALL be set on the same edge (1-cycle latency).
REQ-013 A later valid_in[i] SHALL overwrite register i; captured[i] stays set.
REQ-014 clear=1 SHALL zero all capture registers and captured, and force state IDLE; clear SHALL win over a simultaneous valid_in.
REQ-015 States: IDLE, SHOW.
REQ-016 IDLE -> SHOW on the edge after captured reaches 4'b1111; entry SHALL set frame index to 0 and tick counter to 0.
REQ-017 SHOW -> IDLE only on clear or rst.
REQ-018 IDLE: led = {busy, captured[2:0]}; showing = 0.
REQ-019 Tick counter SHALL run only in SHOW, counting 0..TICK_DIV-1; the frame index SHALL advance on the cycle the count equals TICK_DIV-1, with the counter returning to 0.
REQ-020 Frame index f ranges 0..20; f=20 SHALL wrap to 0.
REQ-021 For f<20: lane L = f/5, k = f mod 5; k=0 is the header, led = one-hot(L), i.e. 4'b0001 << L.
REQ-022 For f<20, k=1..4: led = nibble (4-k) of capture register L, MSB nibble first (k=1 -> bits [15:12]); for other ACC_W, nibbles SHALL be taken from the top 16 bits.
REQ-023 f=20 is the gap frame: led = 4'b0000.
REQ-024 SHOW displays live capture registers; an overwrite (REQ-013) SHALL appear on the next displayed frame without restarting the sequence.
REQ-025 busy SHALL be ignored in SHOW.
REQ-026 Each frame SHALL last exactly TICK_DIV cycles; frame 0 starts on the SHOW entry edge.

Reset
REQ-027 rst SHALL asynchronously set: state IDLE, capture registers 0, captured 0, frame index 0, tick counter 0, showing 0.
REQ-028 Output led under reset SHALL be {busy, 3'b000}.
REQ-029 rst mid-SHOW SHALL abort display immediately; after release, the block SHALL re-enter SHOW only after all four lanes are captured again.

Structure
REQ-030 ACC_W default, N_MACS=4, frame count (21), frames per lane (5) and the state encoding SHALL reside in the shared package systolic_pkg.
REQ-031 The frame prescaler SHALL be a sub-module tick_divider (inputs clk, rst, en; output tick; parameter TICK_DIV).
REQ-032 All outputs SHALL be registered or decoded only from registered state and busy; no combinational path from acc_in or valid_in to led.

Verification (TICK_DIV=4)
REQ-033 rst pulse mid-cycle, busy=1 -> led=4'b1000, captured=0, showing=0 asynchronously.
REQ-034 valid_in=4'b0101 with acc_in_0=16'h1234, acc_in_2=16'h00FF -> next cycle captured=4'b0101, led={busy,3'b101}, showing=0.
REQ-035 Lanes 0..3 captured as 16'h1234, 16'hABCD, 16'h8000, 16'hFFFF -> showing=1; led sequence 1,1,2,3,4, 2,A,B,C,D, 4,8,0,0,0, 8,F,F,F,F, 0, then 1 again, each value held for exactly 4 cycles.
REQ-036 During frame f=6, valid_in[1] with acc_in_1=16'h5555 -> frames 7..9 show 5,5,5; the sequence does not restart.
REQ-037 clear asserted in the same cycle as valid_in=4'b1111 -> captured=0, state IDLE, led={busy,3'b000}.
REQ-038 rst during frame 12, then release, then lanes captured over 3 cycles -> SHOW re-entered with frame 0 (led=4'b0001) on the edge after the last capture.
